// File: rtl/color_histogram_if.sv
// Pixel-in and bin-out streams of the color histogram block.
// Both streams use valid/ready: a beat transfers on a rising clk edge where valid and
// ready are both high; the sender holds its payload stable while valid is high and ready is low.
interface color_histogram_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 13
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bin_valid;
    logic              bin_ready;
    logic [DATA_W-1:0] bin_idx;
    logic [CNT_W-1:0]  bin_count;

    modport master (
        output in_valid, in_data, bin_ready,
        input  in_ready, bin_valid, bin_idx, bin_count
    );

    modport slave (
        input  in_valid, in_data, bin_ready,
        output in_ready, bin_valid, bin_idx, bin_count
    );
endinterface

// File: rtl/color_histogram.sv
// 64-bin color histogram: clear, accumulate one image of quantized pixels, stream bins out.
// Optional running argmax outputs (dom_bin/dom_count) are enabled by COLOR_HIST_DOMINANT_EN.
module color_histogram #(
    parameter int DATA_W     = 6,
    parameter int NUM_PIXELS = 4096,
    parameter int CNT_W      = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    color_histogram_if.slave    bus,
    output logic                busy,
    output logic                done,
`ifdef COLOR_HIST_DOMINANT_EN
    output logic [DATA_W-1:0]   dom_bin,
    output logic [CNT_W-1:0]    dom_count,
`endif
    output logic [2:0]          dbg_state
);
    localparam int NUM_BINS = 1 << DATA_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCUM   = 3'd2,
        S_READOUT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  hist_q [NUM_BINS];

    logic              accept;
    logic              clr_we;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W-1:0]  inc_cnt;

    // Read-modify-write in one cycle, so back-to-back hits on one bin never lose a count.
    assign cur_cnt   = hist_q[bus.in_data];
    assign inc_cnt   = (cur_cnt == {CNT_W{1'b1}}) ? cur_cnt : cur_cnt + 1'b1;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
            rd_idx_q  <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_idx_q  <= rd_idx_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        rd_idx_d      = rd_idx_q;
        pix_cnt_d     = pix_cnt_q;
        accept        = 1'b0;
        clr_we        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.bin_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == DATA_W'(NUM_BINS - 1)) begin
                    state_d   = S_ACCUM;
                    pix_cnt_d = '0;
                end
            end
            S_ACCUM: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == CNT_W'(NUM_PIXELS - 1)) begin
                        state_d   = S_READOUT;
                        pix_cnt_d = '0;
                        rd_idx_d  = '0;
                    end
                end
            end
            S_READOUT: begin
                busy          = 1'b1;
                bus.bin_valid = 1'b1;
                if (bus.bin_ready) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == DATA_W'(NUM_BINS - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        bus.bin_idx   = bus.bin_valid ? rd_idx_q : '0;
        bus.bin_count = bus.bin_valid ? hist_q[rd_idx_q] : '0;
    end

    // Bin storage has no reset; the CLEAR sweep is what zeroes it for each image.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we)      hist_q[clr_idx_q]   <= '0;
            else if (accept) hist_q[bus.in_data] <= inc_cnt;
        end
    end

`ifdef COLOR_HIST_DOMINANT_EN
    logic [DATA_W-1:0] dom_bin_q;
    logic [CNT_W-1:0]  dom_count_q;

    // Only the incremented bin can overtake the leader; ties keep the lower index.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_we) begin
            dom_bin_q   <= '0;
            dom_count_q <= '0;
        end else if (accept) begin
            if ((inc_cnt > dom_count_q) ||
                ((inc_cnt == dom_count_q) && (bus.in_data < dom_bin_q))) begin
                dom_bin_q   <= bus.in_data;
                dom_count_q <= inc_cnt;
            end
        end
    end

    assign dom_bin   = dom_bin_q;
    assign dom_count = dom_count_q;
`endif
endmodule

// File: tb/tb_color_histogram.sv
// Directed bench for color_histogram: bin counts are predicted from the pixels actually
// handed over, and every presented bin is checked against that prediction.
module tb_color_histogram;
  localparam int DATA_W     = 6;
  localparam int CNT_W      = 13;
  localparam int NUM_BINS   = 64;
  localparam int NUM_PIXELS = 4096;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic [2:0] dbg_state;
`ifdef COLOR_HIST_DOMINANT_EN
  logic [DATA_W-1:0] dom_bin;
  logic [CNT_W-1:0]  dom_count;
`endif

  color_histogram_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  color_histogram #(.DATA_W(DATA_W), .NUM_PIXELS(NUM_PIXELS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
`ifdef COLOR_HIST_DOMINANT_EN
    .dom_bin   (dom_bin),
    .dom_count (dom_count),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int model_hist [NUM_BINS];
  int got_count  [NUM_BINS];
  int pix_q [$];
  logic [CNT_W-1:0] exp_q [$];
  int exp_idx = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // scoreboard: every cycle a bin is presented it must be the next expected one
  always @(negedge clk) begin
    if (rst_n && bus.bin_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bin_valid", {26'd0, bus.bin_idx}, 32'hFFFF_FFFF);
      end else begin
        check("bin_idx", {26'd0, bus.bin_idx}, exp_idx);
        check("bin_count", {19'd0, bus.bin_count}, {19'd0, exp_q[0]});
        if (bus.bin_ready) begin
          got_count[bus.bin_idx] = int'(bus.bin_count);
          void'(exp_q.pop_front());
          exp_idx++;
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bin_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 0);
    check({tag, "_bin_valid"}, {31'd0, bus.bin_valid}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_bin_idx"}, {26'd0, bus.bin_idx}, 0);
    check({tag, "_bin_count"}, {19'd0, bus.bin_count}, 0);
  endtask

  task automatic start_image();
    int n;
    for (int b = 0; b < NUM_BINS; b++) begin
      model_hist[b] = 0;
      got_count[b] = -1;
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
    n = 1;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    check("start_to_in_ready", n, 65);
  endtask

  task automatic send_pixels(input bit gaps, input bit finish_image);
    int code;
    int stall;
    bit acc;
    stall = 0;
    while (pix_q.size() > 0) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data = DATA_W'($urandom_range(0, 63));
        @(posedge clk);
        #1;
        continue;
      end
      code = pix_q[0];
      bus.in_valid = 1'b1;
      bus.in_data = code[DATA_W-1:0];
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (model_hist[code] < CNT_MAX) model_hist[code]++;
        void'(pix_q.pop_front());
      end else if (++stall > 100) begin
        check("in_ready_timeout", 0, 1);
        pix_q.delete();
      end
    end
    bus.in_valid = 1'b0;
    if (finish_image) begin
      check("last_pixel_to_bin_valid", {31'd0, bus.bin_valid}, 1);
      check("in_ready_low_in_readout", {31'd0, bus.in_ready}, 0);
      exp_idx = 0;
      for (int b = 0; b < NUM_BINS; b++) exp_q.push_back(CNT_W'(model_hist[b]));
    end
  endtask

  task automatic read_bins(input bit stall);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      bus.bin_ready = stall ? (k % 4 == 3) : 1'b1;
      @(posedge clk);
      #1 k++;
    end
    bus.bin_ready = 1'b0;
    check("readout_complete", exp_q.size(), 0);
    exp_q.delete();
    if (!stall) check("readout_cycles", k, NUM_BINS);
    check("done_after_last_bin", {31'd0, done}, 1);
    check("bin_valid_low_in_done", {31'd0, bus.bin_valid}, 0);
    check("busy_low_in_done", {31'd0, busy}, 0);
`ifdef COLOR_HIST_DOMINANT_EN
    begin
      int best;
      best = 0;
      for (int b = 1; b < NUM_BINS; b++) if (model_hist[b] > model_hist[best]) best = b;
      check("dom_bin_model", {26'd0, dom_bin}, best);
      check("dom_count_model", {19'd0, dom_count}, model_hist[best]);
    end
`endif
  endtask

  task automatic run_image(input int mode, input bit gaps, input bit stall);
    start_image();
    for (int i = 0; i < NUM_PIXELS; i++) begin
      case (mode)
        0: pix_q.push_back(5);
        1: pix_q.push_back(i % 64);
        2: pix_q.push_back(int'($urandom_range(0, 63)));
        3: pix_q.push_back(63);
        4: pix_q.push_back((i % 2 == 1) ? 7 : 9);
        default: pix_q.push_back(i < 2048 ? 10 : 3);
      endcase
    end
    send_pixels(gaps, 1'b1);
    read_bins(stall);
  endtask

  initial begin
    do_reset();
    check_idle_outputs("reset");
    bus.in_valid = 1'b1;
    bus.in_data = 6'd12;
    repeat (3) @(posedge clk);
    #1 check("idle_ignores_in_valid", {31'd0, bus.in_ready}, 0);
    bus.in_valid = 1'b0;

    // basic: every pixel code 5
    run_image(0, 1'b0, 1'b0);
    check("basic_bin5", got_count[5], 4096);
    check("basic_bin0", got_count[0], 0);
    check("basic_bin63", got_count[63], 0);

    // restart from DONE: every pixel code 63, previous image must be gone
    run_image(3, 1'b0, 1'b0);
    check("restart_bin63", got_count[63], 4096);
    check("restart_bin5", got_count[5], 0);

    // uniform codes
    run_image(1, 1'b0, 1'b0);
    check("uniform_bin0", got_count[0], 64);
    check("uniform_bin37", got_count[37], 64);

    // gaps on the input, three stall cycles per bin on the output
    run_image(2, 1'b1, 1'b1);

    // abort mid-accumulation
    start_image();
    for (int i = 0; i < 1000; i++) pix_q.push_back(7);
    send_pixels(1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("after_mid_reset");
    run_image(4, 1'b0, 1'b0);
    check("fresh_bin7", got_count[7], 2048);
    check("fresh_bin9", got_count[9], 2048);
    check("fresh_bin0", got_count[0], 0);

    // two bins tied on count
    run_image(5, 1'b0, 1'b0);
    check("tie_bin3", got_count[3], 2048);
    check("tie_bin10", got_count[10], 2048);
`ifdef COLOR_HIST_DOMINANT_EN
    check("tie_dom_bin", {26'd0, dom_bin}, 3);
    check("tie_dom_count", {19'd0, dom_count}, 2048);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
